branch_operand_forwarder: RTL and testbench

Parametrised branch-operand forwarding and hazard unit for the ID stage of the pipelined CPU. It tracks destination tags of in-flight instructions in EX, MEM and WB through an internal 3-entry tag pipeline, and forwards the youngest matching result to each of NPORTS branch operand ports. It asserts `stall` on load-use hazards and keeps a saturating stall counter for performance monitoring.

---
 rtl/branch_operand_forwarder_pkg.sv | 19 +
 rtl/branch_operand_forwarder_if.sv | 39 +++
 rtl/branch_fwd_port.sv | 56 +++++
 rtl/branch_operand_forwarder.sv | 103 ++++++++++
 tb/tb_branch_operand_forwarder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_operand_forwarder_pkg.sv
// Shared encodings and helpers for the branch operand forwarding unit.
// The forward-source encoding is also used by the ALU forwarding unit.
package branch_operand_forwarder_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Saturating increment for performance counters.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/branch_operand_forwarder_if.sv
// ID-stage bundle between the pipeline controller (master) and the
// branch operand forwarder (slave).
interface branch_operand_forwarder_if
    import branch_operand_forwarder_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int NPORTS = 2
);
    logic                   hold;
    logic                   flush;
    logic                   id_valid;
    logic [NPORTS*AW-1:0]   id_rs;
    logic [NPORTS-1:0]      id_uses;
    logic                   id_we;
    logic                   id_is_load;
    logic [AW-1:0]          id_rd;
    logic [NPORTS*DW-1:0]   rf_data;
    logic [DW-1:0]          ex_alu;
    logic [DW-1:0]          mem_alu;
    logic [DW-1:0]          wb_data;
    logic [NPORTS*DW-1:0]   op_data;
    logic [2*NPORTS-1:0]    fwd_sel;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output hold, flush, id_valid, id_rs, id_uses, id_we, id_is_load, id_rd,
               rf_data, ex_alu, mem_alu, wb_data,
        input  op_data, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_uses, id_we, id_is_load, id_rd,
               rf_data, ex_alu, mem_alu, wb_data,
        output op_data, fwd_sel, stall, stall_cnt
    );

endinterface

// File: rtl/branch_fwd_port.sv
// One branch operand port: tag compare against EX/MEM/WB and a
// youngest-first priority mux. Also flags a hit on a load still in EX/MEM.
module branch_fwd_port
    import branch_operand_forwarder_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] rf_data,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] wb_data,
    input  logic          ex_v,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_ld,
    input  logic          mem_v,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_ld,
    input  logic          wb_v,
    input  logic [AW-1:0] wb_rd,
    output logic [DW-1:0] op_data,
    output logic [1:0]    fwd_sel,
    output logic          is_load_hit
);

    logic rs_zero;
    logic match_ex, match_mem, match_wb;

    assign rs_zero   = (ZERO_REG != 0) && (rs == '0);
    assign match_ex  = ex_v  && (ex_rd  == rs) && !rs_zero;
    assign match_mem = mem_v && (mem_rd == rs) && !rs_zero;
    assign match_wb  = wb_v  && (wb_rd  == rs) && !rs_zero;

    // Load data only exists at WB, so any load match in EX or MEM is a hazard,
    // even if a younger non-load also matches.
    assign is_load_hit = (match_ex && ex_ld) || (match_mem && mem_ld);

    // Youngest producer wins; RF is the fallback.
    always_comb begin
        op_data = rf_data;
        fwd_sel = FWD_RF;
        if (match_ex) begin
            op_data = ex_alu;
            fwd_sel = FWD_EX;
        end else if (match_mem) begin
            op_data = mem_alu;
            fwd_sel = FWD_MEM;
        end else if (match_wb) begin
            op_data = wb_data;
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/branch_operand_forwarder.sv
// Branch operand forwarding and load-use hazard unit for the ID stage.
// Keeps a 3-entry destination tag pipeline (EX, MEM, WB) and a saturating
// stall counter; per-port compare/mux lives in branch_fwd_port.
module branch_operand_forwarder
    import branch_operand_forwarder_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int NPORTS   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_operand_forwarder_if.slave bus
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          ld;
    } tag_t;

    tag_t                   ex_q, mem_q;
    logic                   wb_v;
    logic [AW-1:0]          wb_rd;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic                   rd_ok;
    logic                   stall;
    logic [NPORTS-1:0]      load_hit;
    logic [DW-1:0]          port_data [NPORTS];
    logic [1:0]             port_sel  [NPORTS];

    assign rd_ok = (ZERO_REG == 0) || (bus.id_rd != '0);

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        branch_fwd_port #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rs          (bus.id_rs[AW*p +: AW]),
            .rf_data     (bus.rf_data[DW*p +: DW]),
            .ex_alu      (bus.ex_alu),
            .mem_alu     (bus.mem_alu),
            .wb_data     (bus.wb_data),
            .ex_v        (ex_q.v),
            .ex_rd       (ex_q.rd),
            .ex_ld       (ex_q.ld),
            .mem_v       (mem_q.v),
            .mem_rd      (mem_q.rd),
            .mem_ld      (mem_q.ld),
            .wb_v        (wb_v),
            .wb_rd       (wb_rd),
            .op_data     (port_data[p]),
            .fwd_sel     (port_sel[p]),
            .is_load_hit (load_hit[p])
        );
    end

    // Flatten per-port results onto the bus; only used ports can stall.
    always_comb begin
        bus.op_data = '0;
        bus.fwd_sel = '0;
        stall       = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            bus.op_data[DW*p +: DW] = port_data[p];
            bus.fwd_sel[2*p +: 2]   = port_sel[p];
            if (bus.id_uses[p] && load_hit[p])
                stall = 1'b1;
        end
        stall = stall && bus.id_valid;
    end

    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt_q;

    // Tag pipeline: a stalled or flushed ID instruction enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_v  <= 1'b0;
            wb_rd <= '0;
        end else if (!bus.hold) begin
            ex_q.v  <= bus.id_valid && bus.id_we && !stall && !bus.flush && rd_ok;
            ex_q.rd <= bus.id_rd;
            ex_q.ld <= bus.id_is_load;
            mem_q   <= ex_q;
            wb_v    <= mem_q.v;
            wb_rd   <= mem_q.rd;
        end
    end

    // Stalled-cycle counter; frozen by hold, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall && !bus.hold)
            cnt_q <= sat_inc(cnt_q);
    end

endmodule

// File: tb/tb_branch_operand_forwarder.sv
// Bench for branch_operand_forwarder: directed scenarios plus random traffic,
// all checked against a queue-based model of in-flight instructions.
module tb_branch_operand_forwarder;

    logic clk;
    logic rst_n;

    branch_operand_forwarder_if #(.DW(16), .AW(4), .NPORTS(2)) bus ();

    branch_operand_forwarder #(
        .DW(16), .AW(4), .NPORTS(2), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit quiet  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Model: the last three instructions that left ID, youngest first.
    typedef struct {
        bit       v;
        bit [3:0] rd;
        bit       ld;
    } ent_t;

    ent_t      hist[$];
    bit [15:0] m_cnt;

    function automatic void m_reset();
        ent_t e;
        e.v = 0; e.rd = 0; e.ld = 0;
        hist = {};
        repeat (3) hist.push_back(e);
        m_cnt = 0;
    endfunction

    function automatic bit m_hit(int i, bit [3:0] rs);
        return hist[i].v && hist[i].rd == rs && rs != 0;
    endfunction

    // 0 = RF, otherwise 1 + age of youngest matching producer.
    function automatic int m_src(bit [3:0] rs);
        for (int i = 0; i < 3; i++)
            if (m_hit(i, rs)) return i + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit [3:0] rs;
        if (!bus.id_valid) return 0;
        for (int p = 0; p < 2; p++) begin
            rs = bus.id_rs[4*p +: 4];
            if (bus.id_uses[p])
                for (int i = 0; i < 2; i++)
                    if (m_hit(i, rs) && hist[i].ld) return 1;
        end
        return 0;
    endfunction

    task automatic m_check();
        logic [31:0] e_data;
        logic [3:0]  e_sel;
        int          s;
        for (int p = 0; p < 2; p++) begin
            s = m_src(bus.id_rs[4*p +: 4]);
            e_sel[2*p +: 2] = 2'(s);
            case (s)
                0:       e_data[16*p +: 16] = bus.rf_data[16*p +: 16];
                1:       e_data[16*p +: 16] = bus.ex_alu;
                2:       e_data[16*p +: 16] = bus.mem_alu;
                default: e_data[16*p +: 16] = bus.wb_data;
            endcase
        end
        chk("op_data",   bus.op_data,   e_data);
        chk("fwd_sel",   bus.fwd_sel,   e_sel);
        chk("stall",     bus.stall,     m_stall());
        chk("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    function automatic void m_update();
        ent_t e;
        bit   st;
        st = m_stall();
        if (!bus.hold) begin
            e.v  = bus.id_valid && bus.id_we && !st && !bus.flush && bus.id_rd != 0;
            e.rd = bus.id_rd;
            e.ld = bus.id_is_load;
            hist.push_front(e);
            void'(hist.pop_back());
            if (st && m_cnt != 16'hFFFF) m_cnt++;
        end
    endfunction

    task automatic eval();
        @(negedge clk);
        if (!quiet) m_check();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) m_update();
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic set_id(input bit v, input bit we, input bit ld, input bit [3:0] rd,
                          input bit [3:0] rs0, input bit [3:0] rs1, input bit [1:0] uses);
        bus.id_valid   = v;
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.id_rd      = rd;
        bus.id_rs      = {rs1, rs0};
        bus.id_uses    = uses;
    endtask

    task automatic fixed_data();
        bus.rf_data = 32'h1234_1234;
        bus.ex_alu  = 16'hAAAA;
        bus.mem_alu = 16'hBBBB;
        bus.wb_data = 16'hCCCC;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        fixed_data();
        m_reset();

        // Power-on reset state.
        eval();
        chk("rst_op",   bus.op_data,   32'h1234_1234);
        chk("rst_sel",  bus.fwd_sel,   0);
        chk("rst_stl",  bus.stall,     0);
        chk("rst_cnt",  bus.stall_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // ALU chain: add r3, then branch on r3 as it ages through the pipe.
        set_id(1, 1, 0, 3, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 3, 0, 2'b01);
        eval(); chk("chain_ex_sel",  bus.fwd_sel[1:0], 2'b01); chk("chain_ex_op",  bus.op_data[15:0], 16'hAAAA); adv();
        eval(); chk("chain_mem_sel", bus.fwd_sel[1:0], 2'b10); chk("chain_mem_op", bus.op_data[15:0], 16'hBBBB); adv();
        eval(); chk("chain_wb_sel",  bus.fwd_sel[1:0], 2'b11); chk("chain_wb_op",  bus.op_data[15:0], 16'hCCCC); adv();
        eval(); chk("chain_rf_sel",  bus.fwd_sel[1:0], 2'b00); chk("chain_rf_op",  bus.op_data[15:0], 16'h1234); adv();

        // Priority: r5 in EX and WB -> EX wins.
        set_id(1, 1, 0, 5, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 0, 0, 2'b00); cyc();
        set_id(1, 1, 0, 5, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 5, 0, 2'b01);
        eval(); chk("prio_sel", bus.fwd_sel[1:0], 2'b01); adv();

        // r0 is never forwarded or stalled on, even from a load.
        set_id(1, 1, 1, 0, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 0, 0, 2'b11);
        eval(); chk("r0_sel", bus.fwd_sel, 0); chk("r0_stl", bus.stall, 0); adv();

        // Reset mid-run with r4 in flight.
        set_id(1, 1, 0, 4, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 4, 4, 2'b11);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("mrst_op",  bus.op_data,   32'h1234_1234);
        chk("mrst_sel", bus.fwd_sel,   0);
        chk("mrst_stl", bus.stall,     0);
        chk("mrst_cnt", bus.stall_cnt, 0);
        eval();
        @(posedge clk); #1 rst_n = 1'b1;
        eval(); chk("mrst_nofwd", bus.fwd_sel, 0); adv();

        // Load-use on port 1: two stall cycles, then WB forward.
        set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 7, 2, 2'b11);
        eval(); chk("lu_stl0", bus.stall, 1); chk("lu_p0a", bus.fwd_sel[1:0], 0); adv();
        eval(); chk("lu_stl1", bus.stall, 1); chk("lu_p0b", bus.fwd_sel[1:0], 0); adv();
        eval();
        chk("lu_stl2", bus.stall, 0);
        chk("lu_sel",  bus.fwd_sel[3:2], 2'b11);
        chk("lu_op",   bus.op_data[31:16], 16'hCCCC);
        chk("lu_p0c",  bus.op_data[15:0], 16'h1234);
        chk("lu_cnt",  bus.stall_cnt, 2);
        adv();

        // Hold during a load-use stall: tags and counter frozen.
        set_id(1, 1, 1, 6, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 6, 0, 2'b01);
        eval(); chk("hold_pre", bus.stall, 1); adv();
        bus.hold = 1'b1;
        repeat (3) begin
            eval();
            chk("hold_stl", bus.stall, 1);
            chk("hold_sel", bus.fwd_sel[1:0], 2'b10);
            chk("hold_cnt", bus.stall_cnt, 3);
            adv();
        end
        bus.hold = 1'b0;
        eval(); chk("hold_rel", bus.stall, 1); adv();
        eval(); chk("hold_end", bus.stall, 0); chk("hold_cnt2", bus.stall_cnt, 4); adv();

        // Flushed writer never forwards.
        bus.flush = 1'b1;
        set_id(1, 1, 0, 9, 0, 0, 2'b00); cyc();
        bus.flush = 1'b0;
        set_id(1, 0, 0, 0, 9, 9, 2'b11);
        repeat (3) begin
            eval(); chk("flush_sel", bus.fwd_sel, 0); adv();
        end

        // Random traffic on a small register set to force frequent hits.
        repeat (200) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            bus.hold    = ($urandom_range(0, 7) == 0);
            bus.flush   = ($urandom_range(0, 7) == 0);
            bus.rf_data = $urandom;
            bus.ex_alu  = 16'($urandom);
            bus.mem_alu = 16'($urandom);
            bus.wb_data = 16'($urandom);
            cyc();
        end
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        fixed_data();

        // Counter saturation: 2 stall cycles out of every 3.
        quiet = 1;
        repeat (32770) begin
            set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
            set_id(1, 0, 0, 0, 2, 0, 2'b01); cyc(); cyc();
        end
        quiet = 0;
        set_id(1, 1, 1, 2, 0, 0, 2'b00); cyc();
        set_id(1, 0, 0, 0, 2, 0, 2'b01);
        eval(); chk("sat_stl", bus.stall, 1); chk("sat_cnt", bus.stall_cnt, 16'hFFFF); adv();
        eval(); chk("sat_hold", bus.stall_cnt, 16'hFFFF); adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
